// File: rtl/mac_pkg.sv
// Shared widths and types for the Tiny Tapeout multiply-accumulate tile.
package mac_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int PROD_W = 2 * DATA_W;

  typedef logic [DATA_W-1:0] operand_t;
  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [ACC_W-1:0]  acc_t;

endpackage

// File: rtl/mac_core.sv
// Two-stage unsigned MAC: registered full-width product, then wrapping accumulate.
module mac_core
  import mac_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  input  operand_t a,
  input  operand_t b,
  output acc_t     acc
);

  prod_t prod_q;
  acc_t  acc_q;

  // Accumulation is deliberately modulo 2^ACC_W; the carry out is discarded.
  function automatic acc_t wrap_add(input acc_t x, input prod_t y);
    return x + acc_t'(y);
  endfunction

  // Stage 1: full product of the current operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
    end else if (en) begin
      prod_q <= prod_t'(a) * prod_t'(b);
    end
  end

  // Stage 2: fold the previously registered product into the running sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= wrap_add(acc_q, prod_q);
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/tt_um_mac.sv
// Tiny Tapeout wrapper: operands on ui_in/uio_in, accumulator low byte on uo_out.
module tt_um_mac
  import mac_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  acc_t acc;
  logic unused_acc_hi;

  mac_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ena),
    .a     (ui_in),
    .b     (uio_in),
    .acc   (acc)
  );

  assign uo_out  = acc[7:0];
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // Upper accumulator bits have no pin; they only carry into the next sum.
  assign unused_acc_hi = ^acc[ACC_W-1:8];

endmodule

// File: tb/tb_tt_um_mac.sv
// Directed self-checking bench for tt_um_mac with hand-computed expectations.
module tb_tt_um_mac;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks;
  int n_fail;

  tt_um_mac dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply operands, then advance one rising edge and settle 1 ns past it.
  task automatic step(input logic [7:0] a, input logic [7:0] b);
    ui_in  = a;
    uio_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [7:0] basic_a   [12];
  logic [7:0] basic_b   [12];
  logic [7:0] basic_exp [13];

  initial begin
    n_checks = 0;
    n_fail   = 0;

    basic_a = '{3, 3, 1, 1, 5, 5, 7, 7, 0, 0, 1, 1};
    basic_b = '{2, 2, 4, 4, 3, 3, 2, 2, 0, 0, 1, 1};
    basic_exp = '{0, 6, 12, 16, 20, 35, 50, 64, 78, 78, 78, 79, 80};

    // Reset held with maximal operands: nothing may leak through.
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'hFF;
    uio_in = 8'hFF;
    #1;
    check("rst_uo_initial", uo_out, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_uo", uo_out, 8'h00);
      check("rst_uio_oe", uio_oe, 8'h00);
      check("rst_uio_out", uio_out, 8'h00);
    end

    // Basic accumulate: each pair held two cycles, 13 edges observed.
    ui_in  = 8'h00;
    uio_in = 8'h00;
    rst_n  = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i < 12) step(basic_a[i], basic_b[i]);
      else        step(8'd1, 8'd1);
      check($sformatf("basic_edge%0d", i + 1), uo_out, basic_exp[i]);
    end

    // Max product wraps modulo 2^16: 0xFE01 then 0xFC02.
    do_reset();
    step(8'd255, 8'd255);
    check("wrap_e1", uo_out, 8'h00);
    step(8'd255, 8'd255);
    check("wrap_e2", uo_out, 8'h01);
    step(8'd0, 8'd0);
    check("wrap_e3", uo_out, 8'h02);
    check("wrap_uio_oe", uio_oe, 8'h00);

    // Enable hold: 9*9 is captured by the edge that brings acc to 12.
    do_reset();
    step(8'd3, 8'd2);
    check("hold_e1", uo_out, 8'd0);
    step(8'd3, 8'd2);
    check("hold_e2", uo_out, 8'd6);
    step(8'd9, 8'd9);
    check("hold_e3", uo_out, 8'd12);
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(8'd9, 8'd9);
      check("hold_ena0", uo_out, 8'd12);
    end
    ena = 1'b1;
    step(8'd0, 8'd0);
    check("hold_resume", uo_out, 8'd93);
    step(8'd0, 8'd0);
    check("hold_resume2", uo_out, 8'd93);

    // Async reset mid-run from acc = 50 (two 5*5 products).
    do_reset();
    step(8'd5, 8'd5);
    step(8'd5, 8'd5);
    step(8'd0, 8'd0);
    check("areset_pre", uo_out, 8'd50);
    #1;
    rst_n = 1'b0;
    #1;
    check("areset_immediate", uo_out, 8'd0);
    #2;
    rst_n  = 1'b1;
    ui_in  = 8'd1;
    uio_in = 8'd1;
    step(8'd1, 8'd1);
    check("areset_e1", uo_out, 8'd0);
    step(8'd1, 8'd1);
    check("areset_e2", uo_out, 8'd1);
    step(8'd1, 8'd1);
    check("areset_e3", uo_out, 8'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
